lc3_ctrl_seq: RTL and testbench
===============================

Name: lc3_ctrl_seq

Overview:
Synthesizable, parametrised successor to the LC-3 control FSM. It is a one-state-per-clock Moore microsequencer that drives the datapath mux selects, gates, load enables and memory strobes. It adds a ready/timeout memory handshake, BR/JMP/LD/ST/LEA support, illegal-opcode policy and a sticky error state. It sits between the IR/NZP flags and the datapath, in place of the behavioural FSM.

Parameters:
MEM_TIMEOUT, 15, max cycles spent waiting for R_OUT in one memory state; 0 disables the timeout.
TO_W, 8, width of the wait counter; must satisfy MEM_TIMEOUT < 2**TO_W.
HALT_ON_ILLEGAL, 0, 1 sends unsupported opcodes to ERR; 0 treats them as NOP.

Ports:
i_Clk  in  1  clock, rising edge
i_Rst_n  in  1  asynchronous active-low reset
ir_out  in  16  instruction register contents
n_out,z_out,p_out  in  1 each  condition codes
R_OUT  in  1  memory ready
SR2MUX_SEL  out  1  1 = imm5, 0 = SR2
ADDR1MUX_SEL  out  1  0 = PC, 1 = SR1
ADDR2MUX_SEL  out  2  00 = zero, 10 = off9
MARMUX_SEL  out  1  1 = address adder
PCMUX_SEL  out  2  00 = PC+1, 10 = address adder
MIO_EN, RW  out  1 each  memory enable; RW 1 = write
DR, SR1_SEL, SR2_SEL  out  3 each  register file selects
LD_REG, LD_CC, LD_IR, LD_PC, LD_MAR, LD_MDR  out  1 each  load enables
GateMARMUX, GateALU, GateMDR, GatePC  out  1 each  bus drivers
ALUK  out  2  00 = ADD, 01 = AND, 10 = NOT, 11 = PASSA
o_Err  out  1  sticky error flag
CURRENT_STATE_OUT, NEXT_STATE_OUT  out  8 each  state debug outputs

Behaviour:
- Reset (async, i_Rst_n=0): state = 18, wait counter = 0, BEN = 0, o_Err = 0. All outputs are decoded from state, so in state 18 only that state's signals are high. Releasing reset gives a first fetch on the following edge.
- Outputs are purely combinational from the state register (plus ir_out fields). Unlisted outputs are 0 in every state. One state per clock unless waiting.
- 18: GatePC, LD_MAR, LD_PC, PCMUX=00 -> 28.
- 28: MIO_EN, RW=0, LD_MDR=R_OUT. Stay while R_OUT=0; -> 30 on the edge where R_OUT=1.
- 30: GateMDR, LD_IR -> 32.
- 32: register BEN = (ir[11]&n)|(ir[10]&z)|(ir[9]&p). Dispatch on ir[15:12]:
  - ADD -> 1, AND -> 5, NOT -> 9, BR -> 0, JMP -> 12, LD -> 2, ST -> 3, LEA -> 14.
  - Other opcodes -> 18, or -> ERR if HALT_ON_ILLEGAL=1.
- 1/5/9: GateALU, LD_REG, LD_CC, DR=ir[11:9], SR1=ir[8:6], SR2=ir[2:0], SR2MUX_SEL=ir[5], ALUK 00/01/10 respectively -> 18.
- 0: -> 22 if BEN=1, else -> 18.
- 22: ADDR1=0, ADDR2=10, PCMUX=10, LD_PC -> 18.
- 12: SR1=ir[8:6], ADDR1=1, ADDR2=00, PCMUX=10, LD_PC -> 18.
- 14: ADDR1=0, ADDR2=10, MARMUX=1, GateMARMUX, LD_REG, DR=ir[11:9]. No LD_CC. -> 18.
- 2: as 14 but LD_MAR, no LD_REG -> 25. 25: read handshake as in 28 -> 27. 27: GateMDR, LD_REG, LD_CC, DR=ir[11:9] -> 18.
- 3: MAR <- PC+off9 as in 2 -> 23. 23: SR1=ir[11:9], ALUK=11, GateALU, LD_MDR -> 16. 16: MIO_EN, RW=1; wait on R_OUT -> 18.
- Wait counter: clears on entry to any memory state and increments on each cycle with R_OUT=0. If it equals MEM_TIMEOUT (MEM_TIMEOUT != 0) while R_OUT=0 -> ERR. If R_OUT=1 on that same cycle, the handshake completes (no error).
- ERR (state 63): all control outputs 0, o_Err=1. Exit only via reset.
- Reset asserted mid-memory-access: MIO_EN drops immediately (async). No write completes afterwards.
- NEXT_STATE_OUT shows the combinational next state; CURRENT_STATE_OUT shows the registered state.

Optional Feature:
LC3_SEQ_INDIRECT_EN: when defined, LDI (1010) and STI (1011) are supported.
- LDI: 10 (MAR<-PC+off9) -> 24 (read) -> 26 (GateMDR, LD_MAR) -> 25 -> 27.
- STI: 11 -> 29 (read) -> 31 (GateMDR, LD_MAR) -> 23 -> 16.
- When undefined, 1010/1011 follow the illegal-opcode policy.

Test Plan:
- Reset release, IR=0x1042 (ADD R0,R1,R2), R_OUT=1 immediately -> states 18,28,30,32,1,18; in state 1: LD_REG=1, DR=0, SR1=1, SR2=2, SR2MUX_SEL=0, ALUK=00.
- BR: IR=0x0405 with z=1 -> 32,0,22, LD_PC=1, PCMUX=10; with n=1, z=0, p=0 -> 32,0,18, no LD_PC.
- R_OUT held 0 in state 28 with MEM_TIMEOUT=3 -> exactly 4 cycles in 28, then ERR with o_Err=1; R_OUT=1 on the 4th cycle -> 30 and no error.
- ST IR=0x3605 -> 3,23,16; in 16: RW=1, MIO_EN=1 held until R_OUT pulse, then 18.
- HALT_ON_ILLEGAL=1, IR=0xD000 -> ERR; with HALT_ON_ILLEGAL=0 -> 18.
- i_Rst_n pulsed low in state 16 -> MIO_EN=0 the same cycle; state 18 after release.

Source files
------------

// File: rtl/lc3_ctrl_seq_if.sv
// Control/status bundle between the LC-3 microsequencer (master) and the datapath (slave).
interface lc3_ctrl_seq_if;
    logic [15:0] ir_out;
    logic        n_out;
    logic        z_out;
    logic        p_out;
    logic        R_OUT;

    logic        SR2MUX_SEL;
    logic        ADDR1MUX_SEL;
    logic [1:0]  ADDR2MUX_SEL;
    logic        MARMUX_SEL;
    logic [1:0]  PCMUX_SEL;
    logic        MIO_EN;
    logic        RW;
    logic [2:0]  DR;
    logic [2:0]  SR1_SEL;
    logic [2:0]  SR2_SEL;
    logic        LD_REG;
    logic        LD_CC;
    logic        LD_IR;
    logic        LD_PC;
    logic        LD_MAR;
    logic        LD_MDR;
    logic        GateMARMUX;
    logic        GateALU;
    logic        GateMDR;
    logic        GatePC;
    logic [1:0]  ALUK;
    logic        o_Err;
    logic [7:0]  CURRENT_STATE_OUT;
    logic [7:0]  NEXT_STATE_OUT;

    modport master (
        input  ir_out, n_out, z_out, p_out, R_OUT,
        output SR2MUX_SEL, ADDR1MUX_SEL, ADDR2MUX_SEL, MARMUX_SEL, PCMUX_SEL,
               MIO_EN, RW, DR, SR1_SEL, SR2_SEL,
               LD_REG, LD_CC, LD_IR, LD_PC, LD_MAR, LD_MDR,
               GateMARMUX, GateALU, GateMDR, GatePC, ALUK, o_Err,
               CURRENT_STATE_OUT, NEXT_STATE_OUT
    );

    modport slave (
        output ir_out, n_out, z_out, p_out, R_OUT,
        input  SR2MUX_SEL, ADDR1MUX_SEL, ADDR2MUX_SEL, MARMUX_SEL, PCMUX_SEL,
               MIO_EN, RW, DR, SR1_SEL, SR2_SEL,
               LD_REG, LD_CC, LD_IR, LD_PC, LD_MAR, LD_MDR,
               GateMARMUX, GateALU, GateMDR, GatePC, ALUK, o_Err,
               CURRENT_STATE_OUT, NEXT_STATE_OUT
    );
endinterface

// File: rtl/lc3_ctrl_seq.sv
// LC-3 Moore microsequencer with memory ready/timeout handshake and sticky error state.
// Define LC3_SEQ_INDIRECT_EN to add LDI/STI; otherwise those opcodes are treated as illegal.
module lc3_ctrl_seq #(
    parameter int MEM_TIMEOUT     = 15,
    parameter int TO_W            = 8,
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic            i_Clk,
    input  logic            i_Rst_n,
    lc3_ctrl_seq_if.master  bus
);
    typedef enum logic [7:0] {
        S_BR       = 8'd0,
        S_ADD      = 8'd1,
        S_LD       = 8'd2,
        S_ST       = 8'd3,
        S_AND      = 8'd5,
        S_NOT      = 8'd9,
        S_LDI      = 8'd10,
        S_STI      = 8'd11,
        S_JMP      = 8'd12,
        S_LEA      = 8'd14,
        S_ST_WR    = 8'd16,
        S_FETCH    = 8'd18,
        S_BR_TAKE  = 8'd22,
        S_ST_DATA  = 8'd23,
        S_LDI_RD   = 8'd24,
        S_LD_RD    = 8'd25,
        S_LDI_PTR  = 8'd26,
        S_LD_WB    = 8'd27,
        S_FETCH_RD = 8'd28,
        S_STI_RD   = 8'd29,
        S_FETCH_IR = 8'd30,
        S_STI_PTR  = 8'd31,
        S_DECODE   = 8'd32,
        S_ERR      = 8'd63
    } state_e;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    state_e            state;
    state_e            next_state;
    logic [TO_W-1:0]   wait_cnt;
    logic              ben;
    logic              in_mem;
    logic              timed_out;
    logic              unused_ir;

    assign unused_ir = ^bus.ir_out[4:3];

    assign in_mem    = (state == S_FETCH_RD) || (state == S_LD_RD) || (state == S_ST_WR) ||
                       (state == S_LDI_RD)   || (state == S_STI_RD);
    assign timed_out = (MEM_TIMEOUT != 0) && (wait_cnt == TO_W'(MEM_TIMEOUT));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            ben      <= 1'b0;
        end else begin
            state <= next_state;
            // Every memory state is entered from a non-memory state, so this clears on entry.
            if (!in_mem)
                wait_cnt <= '0;
            else if (!bus.R_OUT)
                wait_cnt <= wait_cnt + TO_W'(1);
            if (state == S_DECODE)
                ben <= (bus.ir_out[11] & bus.n_out) | (bus.ir_out[10] & bus.z_out) |
                       (bus.ir_out[9] & bus.p_out);
        end
    end

    function automatic state_e mem_step(state_e stay, state_e done, logic ready, logic expired);
        if (ready)
            return done;
        else if (expired)
            return S_ERR;
        else
            return stay;
    endfunction

    always_comb begin
        next_state = state;
        unique case (state)
            S_FETCH:    next_state = S_FETCH_RD;
            S_FETCH_RD: next_state = mem_step(S_FETCH_RD, S_FETCH_IR, bus.R_OUT, timed_out);
            S_FETCH_IR: next_state = S_DECODE;
            S_DECODE: begin
                case (bus.ir_out[15:12])
                    OP_ADD: next_state = S_ADD;
                    OP_AND: next_state = S_AND;
                    OP_NOT: next_state = S_NOT;
                    OP_BR:  next_state = S_BR;
                    OP_JMP: next_state = S_JMP;
                    OP_LD:  next_state = S_LD;
                    OP_ST:  next_state = S_ST;
                    OP_LEA: next_state = S_LEA;
`ifdef LC3_SEQ_INDIRECT_EN
                    OP_LDI: next_state = S_LDI;
                    OP_STI: next_state = S_STI;
`endif
                    default: next_state = HALT_ON_ILLEGAL ? S_ERR : S_FETCH;
                endcase
            end
            S_ADD, S_AND, S_NOT, S_BR_TAKE, S_JMP, S_LEA, S_LD_WB:
                        next_state = S_FETCH;
            S_BR:       next_state = ben ? S_BR_TAKE : S_FETCH;
            S_LD:       next_state = S_LD_RD;
            S_LD_RD:    next_state = mem_step(S_LD_RD, S_LD_WB, bus.R_OUT, timed_out);
            S_ST:       next_state = S_ST_DATA;
            S_ST_DATA:  next_state = S_ST_WR;
            S_ST_WR:    next_state = mem_step(S_ST_WR, S_FETCH, bus.R_OUT, timed_out);
`ifdef LC3_SEQ_INDIRECT_EN
            S_LDI:      next_state = S_LDI_RD;
            S_LDI_RD:   next_state = mem_step(S_LDI_RD, S_LDI_PTR, bus.R_OUT, timed_out);
            S_LDI_PTR:  next_state = S_LD_RD;
            S_STI:      next_state = S_STI_RD;
            S_STI_RD:   next_state = mem_step(S_STI_RD, S_STI_PTR, bus.R_OUT, timed_out);
            S_STI_PTR:  next_state = S_ST_DATA;
`endif
            S_ERR:      next_state = S_ERR;
            default:    next_state = S_ERR;
        endcase
    end

    // NOTE: every output gets a default first so no path through the case can infer a latch.
    always_comb begin
        bus.SR2MUX_SEL   = 1'b0;
        bus.ADDR1MUX_SEL = 1'b0;
        bus.ADDR2MUX_SEL = 2'b00;
        bus.MARMUX_SEL   = 1'b0;
        bus.PCMUX_SEL    = 2'b00;
        bus.MIO_EN       = 1'b0;
        bus.RW           = 1'b0;
        bus.DR           = 3'd0;
        bus.SR1_SEL      = 3'd0;
        bus.SR2_SEL      = 3'd0;
        bus.LD_REG       = 1'b0;
        bus.LD_CC        = 1'b0;
        bus.LD_IR        = 1'b0;
        bus.LD_PC        = 1'b0;
        bus.LD_MAR       = 1'b0;
        bus.LD_MDR       = 1'b0;
        bus.GateMARMUX   = 1'b0;
        bus.GateALU      = 1'b0;
        bus.GateMDR      = 1'b0;
        bus.GatePC       = 1'b0;
        bus.ALUK         = 2'b00;
        bus.o_Err        = 1'b0;
        case (state)
            S_FETCH: begin
                bus.GatePC = 1'b1;
                bus.LD_MAR = 1'b1;
                bus.LD_PC  = 1'b1;
            end
            S_FETCH_RD, S_LD_RD, S_LDI_RD, S_STI_RD: begin
                bus.MIO_EN = 1'b1;
                bus.LD_MDR = bus.R_OUT;
            end
            S_FETCH_IR: begin
                bus.GateMDR = 1'b1;
                bus.LD_IR   = 1'b1;
            end
            S_ADD, S_AND, S_NOT: begin
                bus.GateALU    = 1'b1;
                bus.LD_REG     = 1'b1;
                bus.LD_CC      = 1'b1;
                bus.DR         = bus.ir_out[11:9];
                bus.SR1_SEL    = bus.ir_out[8:6];
                bus.SR2_SEL    = bus.ir_out[2:0];
                bus.SR2MUX_SEL = bus.ir_out[5];
                bus.ALUK       = (state == S_ADD) ? 2'b00 : (state == S_AND) ? 2'b01 : 2'b10;
            end
            S_BR_TAKE: begin
                bus.ADDR2MUX_SEL = 2'b10;
                bus.PCMUX_SEL    = 2'b10;
                bus.LD_PC        = 1'b1;
            end
            S_JMP: begin
                bus.SR1_SEL      = bus.ir_out[8:6];
                bus.ADDR1MUX_SEL = 1'b1;
                bus.PCMUX_SEL    = 2'b10;
                bus.LD_PC        = 1'b1;
            end
            S_LEA: begin
                bus.ADDR2MUX_SEL = 2'b10;
                bus.MARMUX_SEL   = 1'b1;
                bus.GateMARMUX   = 1'b1;
                bus.LD_REG       = 1'b1;
                bus.DR           = bus.ir_out[11:9];
            end
            S_LD, S_ST, S_LDI, S_STI: begin
                bus.ADDR2MUX_SEL = 2'b10;
                bus.MARMUX_SEL   = 1'b1;
                bus.GateMARMUX   = 1'b1;
                bus.LD_MAR       = 1'b1;
            end
            S_LD_WB: begin
                bus.GateMDR = 1'b1;
                bus.LD_REG  = 1'b1;
                bus.LD_CC   = 1'b1;
                bus.DR      = bus.ir_out[11:9];
            end
            S_ST_DATA: begin
                bus.SR1_SEL = bus.ir_out[11:9];
                bus.ALUK    = 2'b11;
                bus.GateALU = 1'b1;
                bus.LD_MDR  = 1'b1;
            end
            S_ST_WR: begin
                bus.MIO_EN = 1'b1;
                bus.RW     = 1'b1;
            end
            S_LDI_PTR, S_STI_PTR: begin
                bus.GateMDR = 1'b1;
                bus.LD_MAR  = 1'b1;
            end
            S_ERR:   bus.o_Err = 1'b1;
            default: ;
        endcase
    end

    assign bus.CURRENT_STATE_OUT = state;
    assign bus.NEXT_STATE_OUT    = next_state;
endmodule

// File: tb/tb_lc3_ctrl_seq.sv
// Scoreboard bench for lc3_ctrl_seq: two instances (HALT_ON_ILLEGAL 0 and 1, MEM_TIMEOUT 3) share stimulus.
module tb_lc3_ctrl_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ir;
    logic        n, z, p, r;

    always #5 clk = ~clk;

    lc3_ctrl_seq_if bus0 ();
    lc3_ctrl_seq_if bus1 ();

    assign bus0.ir_out = ir;
    assign bus0.n_out  = n;
    assign bus0.z_out  = z;
    assign bus0.p_out  = p;
    assign bus0.R_OUT  = r;
    assign bus1.ir_out = ir;
    assign bus1.n_out  = n;
    assign bus1.z_out  = z;
    assign bus1.p_out  = p;
    assign bus1.R_OUT  = r;

    lc3_ctrl_seq #(.MEM_TIMEOUT(3), .TO_W(8), .HALT_ON_ILLEGAL(1'b0)) dut0 (
        .i_Clk(clk), .i_Rst_n(rst_n), .bus(bus0));
    lc3_ctrl_seq #(.MEM_TIMEOUT(3), .TO_W(8), .HALT_ON_ILLEGAL(1'b1)) dut1 (
        .i_Clk(clk), .i_Rst_n(rst_n), .bus(bus1));

    typedef enum int {
        ST0, ST1, NXT0, NXT1, ERR0, ERR1, MIO, RW, LDREG, LDCC, LDPC, LDMAR, LDMDR, LDIR,
        GPC, GALU, GMDR, GMARMUX, PCMUX, ADDR1, ADDR2, MARMUX, DR, SR1, SR2, SR2MUX, ALUK
    } sig_e;

    typedef struct {
        string       name;
        sig_e        sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] actual(sig_e s);
        case (s)
            ST0:     return 32'(bus0.CURRENT_STATE_OUT);
            ST1:     return 32'(bus1.CURRENT_STATE_OUT);
            NXT0:    return 32'(bus0.NEXT_STATE_OUT);
            NXT1:    return 32'(bus1.NEXT_STATE_OUT);
            ERR0:    return 32'(bus0.o_Err);
            ERR1:    return 32'(bus1.o_Err);
            MIO:     return 32'(bus0.MIO_EN);
            RW:      return 32'(bus0.RW);
            LDREG:   return 32'(bus0.LD_REG);
            LDCC:    return 32'(bus0.LD_CC);
            LDPC:    return 32'(bus0.LD_PC);
            LDMAR:   return 32'(bus0.LD_MAR);
            LDMDR:   return 32'(bus0.LD_MDR);
            LDIR:    return 32'(bus0.LD_IR);
            GPC:     return 32'(bus0.GatePC);
            GALU:    return 32'(bus0.GateALU);
            GMDR:    return 32'(bus0.GateMDR);
            GMARMUX: return 32'(bus0.GateMARMUX);
            PCMUX:   return 32'(bus0.PCMUX_SEL);
            ADDR1:   return 32'(bus0.ADDR1MUX_SEL);
            ADDR2:   return 32'(bus0.ADDR2MUX_SEL);
            MARMUX:  return 32'(bus0.MARMUX_SEL);
            DR:      return 32'(bus0.DR);
            SR1:     return 32'(bus0.SR1_SEL);
            SR2:     return 32'(bus0.SR2_SEL);
            SR2MUX:  return 32'(bus0.SR2MUX_SEL);
            ALUK:    return 32'(bus0.ALUK);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: everything queued since the last sample is compared at the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            check(cur.name, actual(cur.sig), cur.exp);
        end
    end

    task automatic want(string name, sig_e s, int v);
        sb.push_back('{name, s, 32'(v)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From state 18 with R_OUT=1: 28 -> 30 -> 32.
    task automatic fetch(logic [15:0] instr, string tag);
        ir = instr;
        r  = 1'b1;
        step(); want({tag, "_f28"}, ST0, 28); want({tag, "_f28_mio"}, MIO, 1); want({tag, "_f28_ldmdr"}, LDMDR, 1);
        step(); want({tag, "_f30"}, ST0, 30); want({tag, "_f30_ldir"}, LDIR, 1); want({tag, "_f30_gmdr"}, GMDR, 1);
        step(); want({tag, "_f32"}, ST0, 32);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ir = 16'h0000; n = 1'b0; z = 1'b0; p = 1'b0; r = 1'b0;

        step();
        want("rst_state", ST0, 18); want("rst_err", ERR0, 0); want("rst_gatepc", GPC, 1);
        want("rst_ldmar", LDMAR, 1); want("rst_ldpc", LDPC, 1); want("rst_mio", MIO, 0);
        want("rst_ldreg", LDREG, 0); want("rst_pcmux", PCMUX, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // ADD R0,R1,R2
        fetch(16'h1042, "add");
        want("add_nxt", NXT0, 1);
        step();
        want("add_st", ST0, 1); want("add_ldreg", LDREG, 1); want("add_ldcc", LDCC, 1);
        want("add_dr", DR, 0); want("add_sr1", SR1, 1); want("add_sr2", SR2, 2);
        want("add_sr2mux", SR2MUX, 0); want("add_aluk", ALUK, 0); want("add_galu", GALU, 1);
        step(); want("add_ret", ST0, 18);

        // BRz taken
        z = 1'b1;
        fetch(16'h0405, "brt");
        step(); want("brt_st0", ST0, 0); want("brt_ldpc0", LDPC, 0); want("brt_nxt", NXT0, 22);
        step(); want("brt_st22", ST0, 22); want("brt_ldpc", LDPC, 1); want("brt_pcmux", PCMUX, 2);
        want("brt_addr2", ADDR2, 2); want("brt_addr1", ADDR1, 0);
        step(); want("brt_ret", ST0, 18);

        // BRz not taken with only N set
        n = 1'b1; z = 1'b0;
        fetch(16'h0405, "brn");
        step(); want("brn_st0", ST0, 0); want("brn_nxt", NXT0, 18);
        step(); want("brn_ret", ST0, 18);
        n = 1'b0;

        // JMP R7
        fetch(16'hC1C0, "jmp");
        step(); want("jmp_st", ST0, 12); want("jmp_sr1", SR1, 7); want("jmp_addr1", ADDR1, 1);
        want("jmp_pcmux", PCMUX, 2); want("jmp_ldpc", LDPC, 1); want("jmp_addr2", ADDR2, 0);
        step(); want("jmp_ret", ST0, 18);

        // LEA R3
        fetch(16'hE605, "lea");
        step(); want("lea_st", ST0, 14); want("lea_ldreg", LDREG, 1); want("lea_ldcc", LDCC, 0);
        want("lea_dr", DR, 3); want("lea_gmarmux", GMARMUX, 1); want("lea_marmux", MARMUX, 1);
        step(); want("lea_ret", ST0, 18);

        // LD R5
        fetch(16'h2A05, "ld");
        step(); want("ld_st2", ST0, 2); want("ld_ldmar", LDMAR, 1); want("ld_ldreg2", LDREG, 0);
        step(); want("ld_st25", ST0, 25); want("ld_mio", MIO, 1); want("ld_ldmdr", LDMDR, 1);
        step(); want("ld_st27", ST0, 27); want("ld_gmdr", GMDR, 1); want("ld_ldreg", LDREG, 1);
        want("ld_ldcc", LDCC, 1); want("ld_dr", DR, 5);
        step(); want("ld_ret", ST0, 18);

        // Fetch timeout: R_OUT held low, 4 cycles in 28 then ERR
        r = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            step(); want($sformatf("to_wait%0d", c), ST0, 28); want($sformatf("to_nxt%0d", c), NXT0, 28);
        end
        step(); want("to_wait4", ST0, 28); want("to_nxt4", NXT0, 63);
        step(); want("to_err_st", ST0, 63); want("to_err", ERR0, 1); want("to_err_mio", MIO, 0);
        want("to_err_gpc", GPC, 0);
        step(); want("to_err_sticky", ST0, 63); want("to_err_sticky_flag", ERR0, 1);
        pulse_reset();

        // Ready on the 4th wait cycle completes the fetch, then ST R3
        ir = 16'h3605;
        r  = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            step(); want($sformatf("late_wait%0d", c), ST0, 28);
        end
        step(); r = 1'b1;
        want("late_wait4", ST0, 28); want("late_nxt", NXT0, 30); want("late_ldmdr", LDMDR, 1);
        step(); want("late_st30", ST0, 30); want("late_noerr", ERR0, 0);
        step(); want("st_st32", ST0, 32);
        step(); want("st_st3", ST0, 3); want("st_ldmar", LDMAR, 1); want("st_addr2", ADDR2, 2);
        want("st_gmarmux", GMARMUX, 1);
        r = 1'b0;
        step(); want("st_st23", ST0, 23); want("st_sr1", SR1, 3); want("st_aluk", ALUK, 3);
        want("st_galu", GALU, 1); want("st_ldmdr", LDMDR, 1);
        step(); want("st_st16a", ST0, 16); want("st_mio_a", MIO, 1); want("st_rw_a", RW, 1); want("st_nxt_a", NXT0, 16);
        step(); want("st_st16b", ST0, 16); want("st_mio_b", MIO, 1); want("st_rw_b", RW, 1);
        step(); r = 1'b1;
        want("st_st16c", ST0, 16); want("st_nxt_c", NXT0, 18);
        step(); want("st_ret", ST0, 18); want("st_ret_rw", RW, 0);

        // Reset asserted while the write strobe is up
        fetch(16'h3605, "rst16");
        step();
        r = 1'b0;
        step(); step();
        want("rst16_st16", ST0, 16); want("rst16_mio_pre", MIO, 1);
        step();
        #1 rst_n = 1'b0;
        want("rst16_st", ST0, 18); want("rst16_mio", MIO, 0); want("rst16_rw", RW, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        step(); want("rst16_refetch", ST0, 28); want("rst16_refetch_rw", RW, 0);

        // Illegal opcode policy: 1101
        ir = 16'hD000;
        r  = 1'b1;
        step(); want("ill_st30", ST0, 30);
        step(); want("ill_st32", ST0, 32); want("ill_nxt0", NXT0, 18); want("ill_nxt1", NXT1, 63);
        step(); want("ill_st0", ST0, 18); want("ill_st1", ST1, 63); want("ill_err1", ERR1, 1);
        want("ill_err0", ERR0, 0);
        pulse_reset();

        // LDI opcode: illegal unless the indirect extension is built in
        fetch(16'hA000, "ldi");
`ifdef LC3_SEQ_INDIRECT_EN
        want("ldi_nxt0", NXT0, 10); want("ldi_nxt1", NXT1, 10);
`else
        want("ldi_nxt0", NXT0, 18); want("ldi_nxt1", NXT1, 63);
`endif
        step();
`ifndef LC3_SEQ_INDIRECT_EN
        want("ldi_err1", ERR1, 1); want("ldi_st0", ST0, 18);
`else
        want("ldi_st0", ST0, 10);
`endif

        @(negedge clk);
        #1;
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
